fwd_scoreboard: RTL and testbench

Parametrised forwarding and interlock controller for the decode stage of the MIPS pipeline. It tracks the destination tags of every instruction in flight across `NSTAGE` post-decode stages, plus one iterative multi-cycle unit (mult/div). For each of `NREAD` decode source operands it selects the bypass source and raises a decode stall when the needed result does not yet exist. It replaces fixed two-port EX/MEM/WB forwarding logic with a configurable tag pipeline, load-latency aware interlocks, multi-cycle unit tracking and a stall counter.

---
 rtl/fwd_scoreboard.sv | 128 ++++++++++++
 tb/tb_fwd_scoreboard.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Decode-stage forwarding/interlock controller: tracks destination tags through
// NSTAGE post-decode stages plus one iterative multi-cycle unit.
module fwd_scoreboard #(
  parameter int NREAD  = 2,
  parameter int NSTAGE = 3,
  parameter int REGW   = 5,
  parameter int MC_LAT = 4,
  localparam int RSW   = (NSTAGE > 1) ? $clog2(NSTAGE) : 1,
  localparam int SELW  = $clog2(NSTAGE + 2)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  input  logic [NREAD*REGW-1:0]  id_src,
  input  logic [NREAD-1:0]       id_src_used,
  input  logic [REGW-1:0]        id_dst,
  input  logic                   id_wr,
  input  logic [RSW-1:0]         id_rdy_stage,
  input  logic                   id_mc,
  input  logic                   flush,
  output logic                   stall,
  output logic [NREAD*SELW-1:0]  fwd_sel,
  output logic                   mc_busy,
  output logic                   mc_done,
  output logic [15:0]            stall_cnt
);

  localparam int CW = $clog2(MC_LAT);

  logic [NSTAGE-1:0] v_q, v_d, wr_q, wr_d;
  logic [REGW-1:0]   dst_q [NSTAGE];
  logic [REGW-1:0]   dst_d [NSTAGE];
  logic [RSW-1:0]    rs_q  [NSTAGE];
  logic [RSW-1:0]    rs_d  [NSTAGE];

  logic              mc_busy_q, mc_busy_d;
  logic [CW-1:0]     mc_cnt_q, mc_cnt_d;
  logic [REGW-1:0]   mc_dst_q, mc_dst_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;

  logic              stall_raw;
  logic              issue;

  // Per-port bypass selection: the youngest matching stage entry decides.
  always_comb begin
    logic [REGW-1:0] src;
    logic            hit;
    src       = '0;
    hit       = 1'b0;
    stall_raw = 1'b0;
    fwd_sel   = '0;
    mc_done   = mc_busy_q && (mc_cnt_q == '0);
    for (int unsigned i = 0; i < NREAD; i++) begin
      src = id_src[i*REGW +: REGW];
      hit = 1'b0;
      for (int unsigned k = 0; k < NSTAGE; k++) begin
        if (!hit && v_q[k] && wr_q[k] && (dst_q[k] != '0) && (dst_q[k] == src) &&
            id_src_used[i]) begin
          hit = 1'b1;
          if (32'(rs_q[k]) <= k) fwd_sel[i*SELW +: SELW] = SELW'(k + 1);
          else                   stall_raw = 1'b1;
        end
      end
      if (!hit && mc_busy_q && (mc_dst_q == src) && (src != '0) && id_src_used[i]) begin
        if (mc_done) fwd_sel[i*SELW +: SELW] = SELW'(NSTAGE + 1);
        else         stall_raw = 1'b1;
      end
    end
    if (mc_busy_q && !mc_done && (id_mc || (id_wr && (id_dst == mc_dst_q))))
      stall_raw = 1'b1;
    stall = id_valid && stall_raw;
    issue = id_valid && !stall_raw && !flush;
  end

  always_comb begin
    v_d[0]   = issue;
    wr_d[0]  = id_wr && !id_mc;
    dst_d[0] = id_dst;
    rs_d[0]  = id_rdy_stage;
    for (int unsigned k = 1; k < NSTAGE; k++) begin
      v_d[k]   = v_q[k-1];
      wr_d[k]  = wr_q[k-1];
      dst_d[k] = dst_q[k-1];
      rs_d[k]  = rs_q[k-1];
    end
    if (flush) v_d = '0;

    mc_busy_d = mc_busy_q;
    mc_cnt_d  = mc_cnt_q;
    mc_dst_d  = mc_dst_q;
    if (issue && id_mc) begin
      mc_busy_d = 1'b1;
      mc_cnt_d  = CW'(MC_LAT - 1);
      mc_dst_d  = id_dst;
    end else if (mc_busy_q) begin
      if (mc_cnt_q != '0) mc_cnt_d  = mc_cnt_q - 1'b1;
      else                mc_busy_d = 1'b0;
    end

    stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q         <= '0;
      wr_q        <= '0;
      dst_q       <= '{default: '0};
      rs_q        <= '{default: '0};
      mc_busy_q   <= 1'b0;
      mc_cnt_q    <= '0;
      mc_dst_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      v_q         <= v_d;
      wr_q        <= wr_d;
      dst_q       <= dst_d;
      rs_q        <= rs_d;
      mc_busy_q   <= mc_busy_d;
      mc_cnt_q    <= mc_cnt_d;
      mc_dst_q    <= mc_dst_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mc_busy   = mc_busy_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed test-plan steps followed by random traffic,
// all checked against an issue-history reference model.
module tb_fwd_scoreboard;

  localparam int NREAD  = 2;
  localparam int NSTAGE = 3;
  localparam int REGW   = 5;
  localparam int MC_LAT = 4;
  localparam int RSW    = 2;
  localparam int SELW   = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  id_valid;
  logic [NREAD*REGW-1:0] id_src;
  logic [NREAD-1:0]      id_src_used;
  logic [REGW-1:0]       id_dst;
  logic                  id_wr;
  logic [RSW-1:0]        id_rdy_stage;
  logic                  id_mc;
  logic                  flush;
  logic                  stall;
  logic [NREAD*SELW-1:0] fwd_sel;
  logic                  mc_busy;
  logic                  mc_done;
  logic [15:0]           stall_cnt;

  always #5 clk = ~clk;

  fwd_scoreboard #(.NREAD(NREAD), .NSTAGE(NSTAGE), .REGW(REGW), .MC_LAT(MC_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_dst(id_dst), .id_wr(id_wr),
    .id_rdy_stage(id_rdy_stage), .id_mc(id_mc), .flush(flush), .stall(stall),
    .fwd_sel(fwd_sel), .mc_busy(mc_busy), .mc_done(mc_done), .stall_cnt(stall_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Model: every issued instruction with the cycle it issued in. Its stage in
  // cycle n is n-c-1; anything issued at or before the last flush/reset is dead.
  typedef struct {
    int         c;
    logic [4:0] dst;
    logic       wr;
    int         rs;
  } ent_t;

  ent_t       q[$];
  int         kill_c = -1;
  bit         mc_v   = 1'b0;
  int         mc_c   = 0;
  logic [4:0] mc_d   = '0;
  int         m_scnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(output bit st, output logic [NREAD*SELW-1:0] sel,
                       output bit busy, output bit done);
    int         age, best, brs;
    logic [4:0] src;
    busy = mc_v && (cyc - mc_c) >= 1 && (cyc - mc_c) <= MC_LAT;
    done = busy && (cyc - mc_c) == MC_LAT;
    st   = 1'b0;
    sel  = '0;
    for (int i = 0; i < NREAD; i++) begin
      src  = id_src[i*REGW +: REGW];
      best = -1;
      brs  = 0;
      foreach (q[j]) begin
        age = cyc - q[j].c - 1;
        if (q[j].c > kill_c && age >= 0 && age < NSTAGE && q[j].wr && q[j].dst != 0 &&
            q[j].dst == src && id_src_used[i] && (best < 0 || age < best)) begin
          best = age;
          brs  = q[j].rs;
        end
      end
      if (best >= 0) begin
        if (brs <= best) sel[i*SELW +: SELW] = SELW'(best + 1);
        else             st = 1'b1;
      end else if (busy && mc_d == src && src != 0 && id_src_used[i]) begin
        if (done) sel[i*SELW +: SELW] = SELW'(NSTAGE + 1);
        else      st = 1'b1;
      end
    end
    if (busy && !done && (id_mc || (id_wr && id_dst == mc_d))) st = 1'b1;
    if (!id_valid) st = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic [4:0] dst, input logic wr,
                       input logic [1:0] rs, input logic mc, input logic fl);
    id_valid     = v;
    id_src       = {s1, s0};
    id_src_used  = used;
    id_dst       = dst;
    id_wr        = wr;
    id_rdy_stage = rs;
    id_mc        = mc;
    flush        = fl;
    #4;
  endtask

  task automatic step();
    bit                    st, busy, done;
    logic [NREAD*SELW-1:0] sel;
    ent_t                  e;
    model(st, sel, busy, done);
    chk("stall", stall, st);
    chk("fwd_sel", fwd_sel, sel);
    chk("mc_busy", mc_busy, busy);
    chk("mc_done", mc_done, done);
    chk("stall_cnt", stall_cnt, m_scnt);
    if (flush) kill_c = cyc;
    if (id_valid && !st && !flush) begin
      e.c = cyc; e.dst = id_dst; e.wr = id_wr && !id_mc; e.rs = int'(id_rdy_stage);
      q.push_back(e);
      if (id_mc) begin mc_v = 1'b1; mc_c = cyc; mc_d = id_dst; end
    end
    if (st && m_scnt < 65535) m_scnt++;
    while (q.size() > 0 && cyc - q[0].c > NSTAGE + 1) void'(q.pop_front());
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_stall", stall, 0);
    chk("rst_fwd_sel", fwd_sel, 0);
    chk("rst_mc_busy", mc_busy, 0);
    chk("rst_mc_done", mc_done, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ALU back-to-back
    drive(1, 0, 0, 0, 5, 1, 0, 0, 0); step();
    drive(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
    chk("alu_nostall", stall, 0); chk("alu_fwd1", fwd_sel[2:0], 1); step();
    drive(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
    chk("alu_fwd2", fwd_sel[2:0], 2); step();

    // Load-use
    drive(1, 0, 0, 0, 8, 1, 1, 0, 0); step();
    drive(1, 0, 8, 2'b10, 0, 0, 0, 0, 0);
    chk("lu_stall", stall, 1); step();
    drive(1, 0, 8, 2'b10, 0, 0, 0, 0, 0);
    chk("lu_release", stall, 0); chk("lu_cnt", stall_cnt, 1); chk("lu_fwd", fwd_sel[5:3], 2); step();

    // Youngest writer wins; r0 never matches
    drive(1, 0, 0, 0, 3, 1, 0, 0, 0); step();
    drive(1, 0, 0, 0, 3, 1, 0, 0, 0); step();
    drive(1, 3, 0, 2'b01, 0, 0, 0, 0, 0);
    chk("young_fwd", fwd_sel[2:0], 1); step();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0); step();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0); step();
    drive(1, 0, 0, 2'b11, 0, 0, 0, 0, 0);
    chk("r0_fwd", fwd_sel, 0); chk("r0_nostall", stall, 0); step();

    // Multi-cycle: dependent reader waits for mc_done
    drive(1, 0, 0, 0, 9, 1, 0, 1, 0); step();
    for (int j = 1; j < MC_LAT; j++) begin
      drive(1, 9, 0, 2'b01, 0, 0, 0, 0, 0);
      chk("mc_wait", stall, 1); step();
    end
    drive(1, 9, 0, 2'b01, 0, 0, 0, 0, 0);
    chk("mc_done_hi", mc_done, 1); chk("mc_fwd", fwd_sel[2:0], 4); chk("mc_go", stall, 0); step();
    drive(1, 0, 0, 0, 9, 1, 0, 1, 0); step();
    drive(1, 0, 0, 0, 12, 1, 0, 1, 0);
    chk("mc_struct", stall, 1); step();
    drive(1, 0, 0, 0, 9, 1, 0, 0, 0);
    chk("mc_waw", stall, 1); step();
    repeat (3) begin drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step(); end

    // Flush kills the tracked load and blocks the concurrent issue
    drive(1, 0, 0, 0, 7, 1, 1, 0, 0); step();
    drive(1, 0, 0, 0, 10, 1, 0, 0, 1); step();
    drive(1, 7, 10, 2'b11, 0, 0, 0, 0, 0);
    chk("fl_nostall", stall, 0); chk("fl_sel", fwd_sel, 0); step();

    // Reset in the middle of a multi-cycle op
    drive(1, 0, 0, 0, 9, 1, 0, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("rmid_busy", mc_busy, 0); chk("rmid_cnt", stall_cnt, 0); chk("rmid_done", mc_done, 0);
    q.delete(); mc_v = 1'b0; m_scnt = 0; kill_c = cyc;
    @(posedge clk); cyc++; #1;
    rst_n = 1'b1;
    repeat (MC_LAT + 2) begin
      drive(1, 9, 0, 2'b01, 0, 0, 0, 0, 0);
      chk("rmid_nodone", mc_done, 0); step();
    end

    // Random traffic
    repeat (600) begin
      drive($urandom_range(0, 9) < 8,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
            $urandom_range(0, 9) == 0, $urandom_range(0, 15) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
